// File: rtl/multiplexador_arbitrado_if.sv
// multiplexador_arbitrado_if -- handshake bundle for the arbitrated 2:1 merger.
//   in1_valid/in1_data/in1_ready : producer channel 1 (valid/ready)
//   in2_valid/in2_data/in2_ready : producer channel 2 (valid/ready)
//   out_valid/out_data/out_source/out_ready : registered output towards the consumer
// Modports:
//   slave  : the merger itself (accepts producer words, drives the output register)
//   master : the environment (producers and consumer)
interface multiplexador_arbitrado_if #(
  parameter int unsigned data_bits     = 32,
  parameter int unsigned in1_bits_size = 32,
  parameter int unsigned in2_bits_size = 32
);
  logic                     in1_valid;
  logic [in1_bits_size-1:0] in1_data;
  logic                     in1_ready;
  logic                     in2_valid;
  logic [in2_bits_size-1:0] in2_data;
  logic                     in2_ready;
  logic                     out_valid;
  logic [data_bits-1:0]     out_data;
  logic                     out_source;
  logic                     out_ready;

  modport slave (
    input  in1_valid, in1_data, in2_valid, in2_data, out_ready,
    output in1_ready, in2_ready, out_valid, out_data, out_source
  );

  modport master (
    output in1_valid, in1_data, in2_valid, in2_data, out_ready,
    input  in1_ready, in2_ready, out_valid, out_data, out_source
  );
endinterface

// File: rtl/multiplexador_arbitrado.sv
// multiplexador_arbitrado -- merges two valid/ready producers onto one registered
// output word tagged with its source (0 = channel 1, 1 = channel 2).
// Ports:
//   clk   : system clock, rising edge
//   reset : asynchronous, active-high
//   bus   : multiplexador_arbitrado_if.slave (in1_*, in2_*, out_*)
// Arbitration is round-robin on contention (channel 1 wins the first one after
// reset). Define MULTIPLEXADOR_FIXED_PRIORITY_EN for fixed priority to channel 1.
// Narrow input words are zero-extended to data_bits.
module multiplexador_arbitrado #(
  parameter int unsigned data_bits     = 32,
  parameter int unsigned in1_bits_size = 32,
  parameter int unsigned in2_bits_size = 32
) (
  input  logic                        clk,
  input  logic                        reset,
  multiplexador_arbitrado_if.slave    bus
);

  typedef enum logic {EMPTY, FULL} state_t;

  state_t               state, state_next;
  logic [data_bits-1:0] data_q;
  logic                 source_q;
  logic [data_bits-1:0] ext1, ext2;
  logic                 can_load;
  logic                 ready1, ready2;
  logic                 xfer1, xfer2;
  logic                 take;

`ifndef MULTIPLEXADOR_FIXED_PRIORITY_EN
  // 0 = channel 1 won the last transfer, 1 = channel 2
  logic                 last_grant;
`endif

  always_comb begin
    ext1 = '0;
    ext2 = '0;
    ext1[in1_bits_size-1:0] = bus.in1_data;
    ext2[in2_bits_size-1:0] = bus.in2_data;
  end

  // Each ready is computed from the other channel's valid only, so a producer
  // never sees its own valid fed back into its ready.
  always_comb begin
    can_load = (state == EMPTY) || bus.out_ready;
`ifdef MULTIPLEXADOR_FIXED_PRIORITY_EN
    ready1 = can_load;
    ready2 = can_load && !bus.in1_valid;
`else
    ready1 = can_load && (!bus.in2_valid ||  last_grant);
    ready2 = can_load && (!bus.in1_valid || !last_grant);
`endif
    xfer1 = bus.in1_valid && ready1;
    xfer2 = bus.in2_valid && ready2;
    take  = (state == FULL) && bus.out_ready;

    state_next = state;
    unique case (state)
      EMPTY: if (xfer1 || xfer2)            state_next = FULL;
      FULL:  if (take && !(xfer1 || xfer2)) state_next = EMPTY;
      default:                              state_next = EMPTY;
    endcase
  end

  always_comb begin
    bus.in1_ready  = ready1;
    bus.in2_ready  = ready2;
    bus.out_valid  = (state == FULL);
    bus.out_data   = data_q;
    bus.out_source = source_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= EMPTY;
    else       state <= state_next;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_q   <= '0;
      source_q <= 1'b0;
    end else if (xfer1) begin
      data_q   <= ext1;
      source_q <= 1'b0;
    end else if (xfer2) begin
      data_q   <= ext2;
      source_q <= 1'b1;
    end
  end

`ifndef MULTIPLEXADOR_FIXED_PRIORITY_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)      last_grant <= 1'b1;
    else if (xfer1) last_grant <= 1'b0;
    else if (xfer2) last_grant <= 1'b1;
  end
`endif

endmodule

// File: doc/multiplexador_arbitrado.md
Name: multiplexador_arbitrado

Overview:
- Merges two independent data producers onto one registered output bus; this is the converging counterpart of the team's selector-driven demultiplexer.
- Each input channel and the output use a valid/ready handshake.
- Contention is resolved by round-robin arbitration; the winning word is captured in a one-entry output register tagged with its source.
- Sits in front of the graphics/robot-command path, so two command sources (e.g. Nios bridge and game-logic FSM) can share a single consumer.

Parameters:
- data_bits, 32, width of out_data.
- in1_bits_size, 32, width of in1_data; must be <= data_bits; zero-extended into out_data.
- in2_bits_size, 32, width of in2_data; must be <= data_bits; zero-extended into out_data.

Ports:
- clk  input  1  system clock; all state on rising edge.
- reset  input  1  asynchronous, active-high reset.
- in1_valid  input  1  channel 1 has a word.
- in1_data  input  in1_bits_size  channel 1 word.
- in1_ready  output  1  channel 1 word accepted this cycle when in1_valid && in1_ready.
- in2_valid  input  1  channel 2 has a word.
- in2_data  input  in2_bits_size  channel 2 word.
- in2_ready  output  1  channel 2 accept, same rule as channel 1.
- out_valid  output  1  output register holds a word.
- out_data  output  data_bits  registered output word.
- out_source  output  1  0 = word came from channel 1, 1 = from channel 2 (same polarity as the demultiplexer selector).
- out_ready  input  1  consumer takes the word when out_valid && out_ready.

Behaviour:
- Reset (asynchronous, active-high): out_valid=0, out_data=0, out_source=0, last_grant=1. With last_grant=1, the first contention goes to channel 1.
- Clock and reset: one clock; reset is asynchronous and active-high.
- can_load = !out_valid || out_ready. The register is empty, or is being drained this cycle.
- Grant (combinational):
  - Only in1_valid asserted: grant channel 1.
  - Only in2_valid asserted: grant channel 2.
  - Both asserted: grant the channel opposite last_grant.
  - Neither asserted: no grant.
- inN_ready = can_load && (grant == N).
  - ready may depend combinationally on the other channel's valid and on out_ready.
  - ready must not depend on the same channel's valid. While the other channel is idle, inN_ready = can_load.
- On a transfer at channel N (valid && ready), at the next edge:
  - out_data <= zero-extended inN_data.
  - out_source <= N-1.
  - out_valid <= 1.
  - last_grant <= N-1.
- On an output take with no simultaneous input transfer: out_valid <= 0. out_data and out_source hold their last values.
- Simultaneous take and input transfer: the register is reloaded in the same edge and out_valid stays 1. This gives a sustained throughput of 1 word/cycle.
- out_ready low while out_valid=1: out_data and out_source are frozen, and both readies are 0 (backpressure).
- Latency: an input accepted at edge k is visible on out_* after edge k (1 cycle).
- Fairness: under continuous contention and an always-ready consumer, grants alternate 1,2,1,2...
- last_grant updates only on an actual transfer; it is not changed by a stall.
- Reset mid-operation: a held word is discarded and out_valid drops immediately (asynchronously).
- Zero-extension: out_data[data_bits-1:inN_bits_size] = 0.
- FSM: EMPTY (out_valid=0) and FULL (out_valid=1).
  - EMPTY -> FULL on an input transfer.
  - FULL -> EMPTY on a take with no input transfer.
  - FULL -> FULL on take+load or on a stall.

Optional Feature:
- Macro MULTIPLEXADOR_FIXED_PRIORITY_EN.
- When defined: channel 1 always wins contention. last_grant is neither used nor implemented. Channel 2 is granted only when in1_valid=0.
- When undefined: round-robin arbitration as described above.

Test Plan:
- Reset, then in1_valid=1 with in1_data=32'hA5A5_0001 and out_ready=1 -> next cycle out_valid=1, out_data=32'hA5A5_0001, out_source=0.
- Both valid every cycle (in1=32'h11, in2=32'h22), out_ready=1 for 6 cycles -> out_data sequence 11,22,11,22,11,22. With MULTIPLEXADOR_FIXED_PRIORITY_EN defined -> all 11.
- out_valid=1 holding 32'h22 with out_ready=0 for 3 cycles and in1_valid=1 -> out_data stays 32'h22, in1_ready=0 all 3 cycles. When out_ready is raised, the channel 1 word is loaded on that same edge.
- in2_bits_size=8, data_bits=32, in2_data=8'hFF -> out_data=32'h0000_00FF, out_source=1.
- Assert reset while out_valid=1 -> out_valid=0, out_data=0, out_source=0 immediately, without waiting for a clock edge. After release, both channels valid -> channel 1 is granted first.
